// File: rtl/sign_mag_pkg.sv
// Shared types and defaults for the serial two's-complement to sign-magnitude decoder.
package sign_mag_pkg;

  localparam int WIDTH_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/first_one_flag.sv
// JK-style flag register with synchronous clear; records that a 1 bit has already streamed past.
module first_one_flag (
  input  logic t_clk,
  input  logic rst_n,
  input  logic j_i,
  input  logic k_i,
  input  logic clr_i,
  output logic q_o
);

  logic flag_q, flag_d;

  always_comb begin
    flag_d = flag_q;
    if (clr_i) begin
      flag_d = 1'b0;
    end else begin
      case ({j_i, k_i})
        2'b10:   flag_d = 1'b1;
        2'b01:   flag_d = 1'b0;
        2'b11:   flag_d = ~flag_q;
        default: flag_d = flag_q;
      endcase
    end
  end

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) flag_q <= 1'b0;
    else        flag_q <= flag_d;
  end

  assign q_o = flag_q;

endmodule

// File: rtl/sign_mag_decoder.sv
// Bit-serial two's-complement to sign-magnitude converter with valid/ready handshakes.
// Optional macro SERIAL_OUT_EN adds ser_bit/ser_valid, streaming the data_out word LSB-first.
module sign_mag_decoder
  import sign_mag_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             t_clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             ovf
`ifdef SERIAL_OUT_EN
  ,
  output logic             ser_bit,
  output logic             ser_valid
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sign_q, sign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q;
  logic             xfer, bit_active, in_bit, out_bit;

  assign in_ready   = (state_q == IDLE);
  assign xfer       = in_valid & in_ready;
  // The counter parks at WIDTH for one cycle before DONE, giving WIDTH+1 edges of latency.
  assign bit_active = (state_q == SHIFT) && (cnt_q != CNT_LAST);
  assign in_bit     = shift_q[0];
  assign out_bit    = (sign_q & flag_q) ? ~in_bit : in_bit;

  first_one_flag u_first_one_flag (
    .t_clk (t_clk),
    .rst_n (rst_n),
    .j_i   (bit_active & in_bit),
    .k_i   (1'b0),
    .clr_i (xfer),
    .q_o   (flag_q)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    result_d = result_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          shift_d  = data_in;
          result_d = '0;
          sign_d   = data_in[WIDTH-1];
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_active) begin
          shift_d  = shift_q >> 1;
          result_d = {out_bit, result_q[WIDTH-1:1]};
          cnt_d    = cnt_q + CNT_W'(1);
        end else begin
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
    end
  end

  // A negative input whose complement still has the MSB set is -2^(WIDTH-1); its magnitude field is 0.
  assign out_valid = (state_q == DONE);
  assign ovf       = out_valid & sign_q & result_q[WIDTH-1];
  assign data_out  = out_valid ? {sign_q, result_q[WIDTH-2:0]} : '0;

`ifdef SERIAL_OUT_EN
  localparam logic [CNT_W-1:0] CNT_MSB = CNT_W'(WIDTH - 1);

  // The last serial slot carries the sign so the stream matches data_out bit for bit.
  assign ser_valid = bit_active;
  assign ser_bit   = bit_active & ((cnt_q == CNT_MSB) ? sign_q : out_bit);
`endif

endmodule

// File: tb/tb_sign_mag_decoder.sv
// Self-checking bench for sign_mag_decoder: transaction-level model, per-cycle compare, directed and random traffic.
module tb_sign_mag_decoder;

  localparam int W = 12;

  logic         t_clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_out;
  logic         ovf;
`ifdef SERIAL_OUT_EN
  logic         ser_bit;
  logic         ser_valid;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sign_mag_decoder #(.WIDTH(W)) dut (
    .t_clk     (t_clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .ovf       (ovf)
`ifdef SERIAL_OUT_EN
    ,
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid)
`endif
  );

  always #5 t_clk = ~t_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference conversion from plain arithmetic on the two's-complement value.
  function automatic logic [W-1:0] ref_out(input logic [W-1:0] x);
    logic [W-1:0] mag;
    if (!x[W-1]) return x;
    mag = -x;
    return {1'b1, mag[W-2:0]};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x);
    return x == {1'b1, {(W-1){1'b0}}};
  endfunction

  // Transaction model: one word in flight, identified by its capture edge.
  int           cyc  = 0;
  int           xc   = 0;
  bit           busy = 1'b0;
  logic [W-1:0] word = '0;

  always @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 1'b0;
    end else begin
      if (!busy) begin
        if (in_valid) begin
          busy = 1'b1;
          xc   = cyc + 1;
          word = data_in;
        end
      end else if ((cyc - xc) >= W + 1 && out_ready) begin
        busy = 1'b0;
      end
      cyc++;
    end
  end

  always @(negedge t_clk) begin
    int d;
    d = cyc - xc;
    if (!rst_n || !busy) begin
      chk("m_in_ready", in_ready, 1'b1);
      chk("m_out_valid", out_valid, 1'b0);
      chk("m_data_out", data_out, '0);
      chk("m_ovf", ovf, 1'b0);
`ifdef SERIAL_OUT_EN
      chk("m_ser_valid", ser_valid, 1'b0);
`endif
    end else if (d <= W) begin
      chk("m_in_ready", in_ready, 1'b0);
      chk("m_out_valid", out_valid, 1'b0);
      chk("m_data_out", data_out, '0);
      chk("m_ovf", ovf, 1'b0);
`ifdef SERIAL_OUT_EN
      chk("m_ser_valid", ser_valid, d < W);
      if (d < W) chk("m_ser_bit", ser_bit, ref_out(word)[d]);
`endif
    end else begin
      chk("m_in_ready", in_ready, 1'b0);
      chk("m_out_valid", out_valid, 1'b1);
      chk("m_data_out", data_out, ref_out(word));
      chk("m_ovf", ovf, ref_ovf(word));
`ifdef SERIAL_OUT_EN
      chk("m_ser_valid", ser_valid, 1'b0);
`endif
    end
  end

  // Called at posedge+1 with the DUT idle; returns the captured serial stream.
  task automatic send(input logic [W-1:0] w, input logic [W-1:0] exp_d, input logic exp_o,
                      input int hold, output logic [W-1:0] ser_seq, output int ser_n);
    int n;
    ser_seq   = '0;
    ser_n     = 0;
    in_valid  = 1'b1;
    data_in   = w;
    out_ready = 1'b0;
    @(posedge t_clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
`ifdef SERIAL_OUT_EN
      if (ser_valid) begin
        if (ser_n < W) ser_seq[ser_n] = ser_bit;
        ser_n++;
      end
`endif
      @(posedge t_clk); #1;
      n++;
    end
    chk("latency", n, W + 1);
    chk("data_out", data_out, exp_d);
    chk("ovf", ovf, exp_o);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      data_in  = W'($urandom);
      @(posedge t_clk); #1;
      in_valid = 1'b0;
      chk("hold_data", data_out, exp_d);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge t_clk); #1;
    out_ready = 1'b0;
    chk("release_in_ready", in_ready, 1'b1);
    chk("release_data", data_out, '0);
  endtask

  initial begin
    logic [W-1:0] seq;
    int           sn;
    logic [W-1:0] pick;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data_out", data_out, '0);
    chk("rst_ovf", ovf, 1'b0);
    repeat (2) @(posedge t_clk);
    #1 rst_n = 1'b1;

    send(12'h005, 12'h005, 1'b0, 0, seq, sn);
    send(12'hFFB, 12'h805, 1'b0, 0, seq, sn);
`ifdef SERIAL_OUT_EN
    chk("ser_count", sn, W);
    chk("ser_seq", seq, 12'h805);
`endif
    send(12'hFFF, 12'h801, 1'b0, 0, seq, sn);
    send(12'h800, 12'h800, 1'b1, 0, seq, sn);
    send(12'h7FF, 12'h7FF, 1'b0, 0, seq, sn);
    send(12'h000, 12'h000, 1'b0, 0, seq, sn);
    send(12'h801, 12'hFFF, 1'b0, 5, seq, sn);

    // Reset in the middle of a conversion.
    in_valid = 1'b1;
    data_in  = 12'h123;
    @(posedge t_clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge t_clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_data_out", data_out, '0);
    @(posedge t_clk); #1;
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", in_ready, 1'b1);
    @(posedge t_clk); #1;
    send(12'hFF0, 12'h810, 1'b0, 0, seq, sn);

    // Random traffic with corner-biased data and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(posedge t_clk); #1;
      case ($urandom_range(0, 7))
        0:       pick = 12'h800;
        1:       pick = 12'hFFF;
        2:       pick = 12'h000;
        default: pick = W'($urandom);
      endcase
      data_in   = pick;
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 299) != 0);
    end
    @(posedge t_clk); #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge t_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
